// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry response FIFO (latency 1).
// Optional compressed-format decode (codes 8-10) enabled by IMM_GEN_RVC_EN.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instruction_i,
  input  logic [3:0]       imm_op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o,
  input  logic             flush_i
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t            r_state;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [XLEN-1:0]   r_imm     [2];
  logic [TAG_W-1:0]  r_tag     [2];
  logic              r_illegal [2];

  logic [31:0]       w_raw;
  logic              w_sext;
  logic              w_illegal;
  logic [XLEN-1:0]   w_imm;
  logic              w_push;
  logic              w_pop;

  // Decode: w_raw already holds the 32-bit value; w_sext selects how it widens to XLEN.
  always_comb begin
    w_raw     = '0;
    w_sext    = 1'b0;
    w_illegal = 1'b0;
    case (imm_op_i)
      4'd0: begin
        w_raw  = {{20{instruction_i[31]}}, instruction_i[31:20]};
        w_sext = 1'b1;
      end
      4'd1: begin
        w_raw  = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
        w_sext = 1'b1;
      end
      4'd2: begin
        w_raw  = {{20{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                  instruction_i[11:8], 1'b0};
        w_sext = 1'b1;
      end
      4'd3: begin
        w_raw  = {instruction_i[31:12], 12'b0};
        w_sext = 1'b1;
      end
      4'd4: begin
        w_raw  = {{12{instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                  instruction_i[30:21], 1'b0};
        w_sext = 1'b1;
      end
      4'd5: w_raw = {27'b0, instruction_i[19:15]};
      4'd6: begin
        if (XLEN == 64) w_raw = {26'b0, instruction_i[25:20]};
        else            w_raw = {27'b0, instruction_i[24:20]};
      end
      4'd7: w_raw = '0;
`ifdef IMM_GEN_RVC_EN
      4'd8: begin
        w_raw  = {{26{instruction_i[12]}}, instruction_i[12], instruction_i[6:2]};
        w_sext = 1'b1;
      end
      4'd9: begin
        w_raw  = {{20{instruction_i[12]}}, instruction_i[12], instruction_i[8],
                  instruction_i[10:9], instruction_i[6], instruction_i[7],
                  instruction_i[2], instruction_i[11], instruction_i[5:3], 1'b0};
        w_sext = 1'b1;
      end
      4'd10: begin
        w_raw  = {{23{instruction_i[12]}}, instruction_i[12], instruction_i[6:5],
                  instruction_i[2], instruction_i[11:10], instruction_i[4:3], 1'b0};
        w_sext = 1'b1;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm  = w_sext ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
  assign w_push = in_valid_i & r_in_ready;
  assign w_pop  = r_out_valid & out_ready_i;

  // Occupancy FSM; ready/valid are registered copies of the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= EMPTY;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush_i) begin
      r_state     <= EMPTY;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_push) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_pop) begin
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        r_imm[i]     <= '0;
        r_tag[i]     <= '0;
        r_illegal[i] <= 1'b0;
      end
    end else if (w_push && !flush_i) begin
      r_imm[r_wr_ptr]     <= w_imm;
      r_tag[r_wr_ptr]     <= tag_i;
      r_illegal[r_wr_ptr] <= w_illegal;
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign imm_o       = r_imm[r_rd_ptr];
  assign tag_o       = r_tag[r_rd_ptr];
  assign illegal_o   = r_illegal[r_rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed cases plus random traffic against a queue model.
// Compressed-format expectations follow IMM_GEN_RVC_EN.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instruction_i;
  logic [3:0]       imm_op_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             illegal_o;
  logic             flush_i;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instruction_i(instruction_i), .imm_op_i(imm_op_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .imm_o(imm_o), .tag_o(tag_o), .illegal_o(illegal_o),
    .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  ent_t             q[$];
  logic [TAG_W-1:0] delivered[$];
  int               n_assert = 0;
  int               n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic longint fld(input logic [31:0] x, input int p, input int n);
    return longint'((x >> p) & ((32'd1 << n) - 32'd1));
  endfunction

  // Immediate value from the field-placement rules, as signed arithmetic.
  function automatic ent_t model(input logic [31:0] ins, input logic [3:0] op,
                                 input logic [TAG_W-1:0] tag);
    ent_t   e;
    longint s   = longint'($signed(ins));
    longint sgn = s >>> 31;
    longint c12 = fld(ins, 12, 1);
    longint v   = 0;
    e.ill = 1'b0;
    case (op)
      4'd0: v = s >>> 20;
      4'd1: v = (s >>> 25) * 32 + fld(ins, 7, 5);
      4'd2: v = sgn * 4096 + fld(ins, 7, 1) * 2048 + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2;
      4'd3: v = (s >>> 12) * 4096;
      4'd4: v = sgn * 1048576 + fld(ins, 12, 8) * 4096 + fld(ins, 20, 1) * 2048
                + fld(ins, 21, 10) * 2;
      4'd5: v = fld(ins, 15, 5);
      4'd6: v = (XLEN == 64) ? fld(ins, 20, 6) : fld(ins, 20, 5);
      4'd7: v = 0;
`ifdef IMM_GEN_RVC_EN
      4'd8: v = -c12 * 32 + fld(ins, 2, 5);
      4'd9: v = -c12 * 2048 + fld(ins, 8, 1) * 1024 + fld(ins, 9, 2) * 256 + fld(ins, 6, 1) * 128
                + fld(ins, 7, 1) * 64 + fld(ins, 2, 1) * 32 + fld(ins, 11, 1) * 16
                + fld(ins, 3, 3) * 2;
      4'd10: v = -c12 * 256 + fld(ins, 5, 2) * 64 + fld(ins, 2, 1) * 32 + fld(ins, 10, 2) * 8
                 + fld(ins, 3, 2) * 2;
`endif
      default: begin
        v     = 0;
        e.ill = 1'b1;
      end
    endcase
    if (c12 > 1) e.ill = 1'b1;
    e.imm = XLEN'(v);
    e.tag = tag;
    return e;
  endfunction

  task automatic check_all(input string where);
    chk({where, ":out_valid"}, 64'(out_valid_o), 64'(q.size() != 0));
    chk({where, ":in_ready"}, 64'(in_ready_o), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk({where, ":imm"}, 64'(imm_o), 64'(q[0].imm));
      chk({where, ":tag"}, 64'(tag_o), 64'(q[0].tag));
      chk({where, ":illegal"}, 64'(illegal_o), 64'(q[0].ill));
    end
  endtask

  // One clock: drive, apply the handshake to the model at the edge, check at the falling edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [3:0] op,
                      input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                      input string where);
    bit push, pop;
    in_valid_i    = iv;
    instruction_i = ins;
    imm_op_i      = op;
    tag_i         = tag;
    out_ready_i   = ordy;
    flush_i       = fl;
    push = iv && (q.size() < 2);
    pop  = ordy && (q.size() != 0);
    @(posedge clk_i);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) delivered.push_back(q.pop_front().tag);
      if (push) q.push_back(model(ins, op, tag));
    end
    @(negedge clk_i);
    check_all(where);
  endtask

  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0; instruction_i = '0; imm_op_i = '0; tag_i = '0;
    out_ready_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("rst:out_valid", 64'(out_valid_o), 64'd0);
    chk("rst:in_ready", 64'(in_ready_o), 64'd1);
    chk("rst:imm", 64'(imm_o), 64'd0);
    chk("rst:tag", 64'(tag_o), 64'd0);
    chk("rst:illegal", 64'(illegal_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all("idle");

    // I format, one cycle after acceptance
    step(1'b1, 32'hFFF00093, 4'd0, 4'd5, 1'b0, 1'b0, "i_fmt");
    chk("i_fmt:imm_const", 64'(imm_o), 64'hFFFFFFFF);
    chk("i_fmt:ill_const", 64'(illegal_o), 64'd0);
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "i_pop");

    step(1'b1, 32'hFE000EE3, 4'd2, 4'd6, 1'b0, 1'b0, "b_fmt");
    chk("b_fmt:imm_const", 64'(imm_o), 64'hFFFFFFFC);
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "b_pop");

    step(1'b1, 32'h12345678, 4'd15, 4'd7, 1'b0, 1'b0, "illegal");
    chk("illegal:imm_const", 64'(imm_o), 64'd0);
    chk("illegal:ill_const", 64'(illegal_o), 64'd1);
    chk("illegal:tag_const", 64'(tag_o), 64'd7);
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "illegal_pop");

    step(1'b1, 32'h000010FD, 4'd8, 4'd3, 1'b0, 1'b0, "rvc");
`ifdef IMM_GEN_RVC_EN
    chk("rvc:imm_const", 64'(imm_o), 64'hFFFFFFFF);
    chk("rvc:ill_const", 64'(illegal_o), 64'd0);
`else
    chk("rvc:imm_const", 64'(imm_o), 64'd0);
    chk("rvc:ill_const", 64'(illegal_o), 64'd1);
`endif
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "rvc_pop");

    // Backpressure: third request held until space frees up
    delivered.delete();
    step(1'b1, 32'h00100093, 4'd0, 4'd1, 1'b0, 1'b0, "bp1");
    step(1'b1, 32'h00200093, 4'd0, 4'd2, 1'b0, 1'b0, "bp2");
    chk("bp:in_ready_low", 64'(in_ready_o), 64'd0);
    step(1'b1, 32'h00300093, 4'd0, 4'd3, 1'b1, 1'b0, "bp3");
    step(1'b1, 32'h00300093, 4'd0, 4'd3, 1'b1, 1'b0, "bp4");
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "bp5");
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "bp6");
    chk("bp:count", 64'(delivered.size()), 64'd3);
    for (int i = 0; i < delivered.size(); i++)
      chk("bp:order", 64'(delivered[i]), 64'(i + 1));

    // Flush from FULL
    step(1'b1, 32'hFFF00093, 4'd0, 4'd4, 1'b0, 1'b0, "fl1");
    step(1'b1, 32'h80000037, 4'd3, 4'd5, 1'b0, 1'b0, "fl2");
    step(1'b1, 32'h0, 4'd0, 4'd6, 1'b1, 1'b1, "flush");
    chk("flush:out_valid", 64'(out_valid_o), 64'd0);

    // Asynchronous reset between edges with a full FIFO
    step(1'b1, 32'hFFF00093, 4'd0, 4'd8, 1'b0, 1'b0, "rf1");
    step(1'b1, 32'hFE000EE3, 4'd2, 4'd9, 1'b0, 1'b0, "rf2");
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    q.delete();
    chk("arst:out_valid", 64'(out_valid_o), 64'd0);
    chk("arst:in_ready", 64'(in_ready_o), 64'd1);
    chk("arst:imm", 64'(imm_o), 64'd0);
    chk("arst:tag", 64'(tag_o), 64'd0);
    chk("arst:illegal", 64'(illegal_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1'b0, 32'h0, 4'd0, 4'd0, 1'b1, 1'b0, "post_rst");

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           TAG_W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
